// File: rtl/fifo_packer_pkg.sv
// Shared types and width helpers for the FIFO-to-wide-beat packer.
// The state enum is exported so the bench can observe FILL/PEND directly.
package fifo_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

    // Never returns 0, so a derived width is always a legal vector width.
    function automatic int clog2s(input int value);
        return (value < 2) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/fifo_packer_if.sv
// FIFO read handshake plus wide output beat handshake for fifo_packer.
// Handshake rule: a transfer happens on any edge where valid & ready; valid never waits on ready.
interface fifo_packer_if import fifo_packer_pkg::*; #(
    parameter int C_IN_WIDTH  = 32,
    parameter int C_RATIO     = 4,
    parameter int C_CNT_WIDTH = clog2s(C_RATIO + 1)
);
    logic [C_IN_WIDTH-1:0]         RD_DATA;
    logic                          RD_VALID;
    logic                          RD_READY;
    logic                          FLUSH;
    logic [C_IN_WIDTH*C_RATIO-1:0] OUT_DATA;
    logic [C_CNT_WIDTH-1:0]        OUT_WORDS;
    logic                          OUT_VALID;
    logic                          OUT_READY;

    // master: the FIFO and the downstream consumer around the packer
    modport master (
        output RD_DATA, RD_VALID, FLUSH, OUT_READY,
        input  RD_READY, OUT_DATA, OUT_WORDS, OUT_VALID
    );

    // slave: the packer itself
    modport slave (
        input  RD_DATA, RD_VALID, FLUSH, OUT_READY,
        output RD_READY, OUT_DATA, OUT_WORDS, OUT_VALID
    );
endinterface

// File: rtl/fifo_packer.sv
// Packs C_RATIO narrow FIFO words into one wide beat; FLUSH emits a partial beat.
// One output register plus one pending accumulator give two beats of backpressure slack.
module fifo_packer import fifo_packer_pkg::*; #(
    parameter int C_IN_WIDTH  = 32,
    parameter int C_RATIO     = 4,
    parameter int C_CNT_WIDTH = clog2s(C_RATIO + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    fifo_packer_if.slave bus,
    output state_t       DBG_STATE
);
    localparam logic [C_CNT_WIDTH-1:0] LAST_LANE = C_CNT_WIDTH'(C_RATIO - 1);

    state_t                        rState, nextState;
    logic [C_CNT_WIDTH-1:0]        rCount, nextCount, fillCount;
    logic [C_IN_WIDTH-1:0]         rAcc [C_RATIO];
    logic [C_IN_WIDTH-1:0]         accNext [C_RATIO];
    logic [C_IN_WIDTH*C_RATIO-1:0] rOutData, packedBeat;
    logic [C_CNT_WIDTH-1:0]        rOutWords;
    logic                          rOutValid;
    logic                          rdReady, accept, outFree, complete, loadOut;

    // RD_READY comes from registered state only, never from OUT_READY.
    assign rdReady   = (rState == FILL) & ~RST;
    assign accept    = bus.RD_VALID & rdReady;
    assign outFree   = ~rOutValid | bus.OUT_READY;
    assign fillCount = rCount + C_CNT_WIDTH'(accept);

    always_comb begin
        for (int i = 0; i < C_RATIO; i++) begin
            accNext[i] = rAcc[i];
            if (accept && rCount == C_CNT_WIDTH'(i)) accNext[i] = bus.RD_DATA;
        end
    end

    // In PEND no word is accepted, so accNext/fillCount already equal the held beat.
    always_comb begin
        packedBeat = '0;
        for (int i = 0; i < C_RATIO; i++) begin
            if (C_CNT_WIDTH'(i) < fillCount) packedBeat[i*C_IN_WIDTH +: C_IN_WIDTH] = accNext[i];
        end
    end

    always_comb begin
        nextState = rState;
        nextCount = fillCount;
        complete  = 1'b0;
        loadOut   = 1'b0;
        case (rState)
            FILL: begin
                complete = (accept && rCount == LAST_LANE) || (bus.FLUSH && fillCount != '0);
                if (complete) begin
                    if (outFree) begin
                        loadOut   = 1'b1;
                        nextCount = '0;
                    end else begin
                        nextState = PEND;
                    end
                end
            end
            PEND: begin
                if (outFree) begin
                    loadOut   = 1'b1;
                    nextCount = '0;
                    nextState = FILL;
                end
            end
            default: nextState = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) rState <= FILL;
        else     rState <= nextState;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rCount    <= '0;
            rOutValid <= 1'b0;
            rOutData  <= '0;
            rOutWords <= '0;
        end else begin
            rCount <= nextCount;
            if (loadOut) begin
                rOutData  <= packedBeat;
                rOutWords <= fillCount;
                rOutValid <= 1'b1;
            end else if (bus.OUT_READY) begin
                rOutValid <= 1'b0;
            end
        end
    end

    // Lane contents need no reset: lanes at or above the count are masked on load.
    always_ff @(posedge CLK) begin
        rAcc <= accNext;
    end

    assign bus.RD_READY  = rdReady;
    assign bus.OUT_DATA  = rOutData;
    assign bus.OUT_WORDS = rOutWords;
    assign bus.OUT_VALID = rOutValid;
    assign DBG_STATE     = rState;

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: directed scenarios and random traffic against a queue-based model.
// The model tracks held words as a queue and emits beats from the completion rules.
module tb_fifo_packer;
    import fifo_packer_pkg::*;

    localparam int W  = 32;
    localparam int R  = 4;
    localparam int CW = clog2s(R + 1);
    localparam int DW = W * R;
    localparam int BW = CW + DW;

    logic   CLK = 1'b0;
    logic   RST = 1'b1;
    state_t dbgState;

    fifo_packer_if #(.C_IN_WIDTH(W), .C_RATIO(R)) bus ();

    fifo_packer #(.C_IN_WIDTH(W), .C_RATIO(R)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .DBG_STATE (dbgState)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  srcQ[$];
    logic [W-1:0]  mAcc[$];
    logic [BW-1:0] expQ[$];
    logic [BW-1:0] seenQ[$];
    bit            mPend     = 1'b0;
    bit            mOutValid = 1'b0;
    logic [W-1:0]  w [6];

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelEmit();
        logic [DW-1:0] d;
        d = '0;
        foreach (mAcc[i]) d[i*W +: W] = mAcc[i];
        expQ.push_back({CW'(mAcc.size()), d});
        mAcc.delete();
        mOutValid = 1'b1;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst, input bit vld, input bit flush, input bit ordy);
        bit accept, free, complete;
        @(negedge CLK);
        RST           = rst;
        bus.RD_VALID  = vld && (srcQ.size() > 0);
        bus.RD_DATA   = (srcQ.size() > 0) ? srcQ[0] : '0;
        bus.FLUSH     = flush;
        bus.OUT_READY = ordy;
        #1;
        check("rd_ready", BW'(bus.RD_READY), BW'(!rst && !mPend));
        check("out_valid", BW'(bus.OUT_VALID), BW'(mOutValid));
        if (mOutValid && !rst && expQ.size() > 0) begin
            check("beat", {bus.OUT_WORDS, bus.OUT_DATA}, expQ[0]);
            if (ordy) seenQ.push_back({bus.OUT_WORDS, bus.OUT_DATA});
        end
        if (rst) begin
            mAcc.delete();
            expQ.delete();
            mPend     = 1'b0;
            mOutValid = 1'b0;
        end else begin
            accept = bus.RD_VALID && !mPend;
            free   = !mOutValid || ordy;
            if (mOutValid && ordy) begin
                void'(expQ.pop_front());
                mOutValid = 1'b0;
            end
            if (accept) mAcc.push_back(srcQ.pop_front());
            if (!mPend) begin
                complete = (accept && mAcc.size() == R) || (flush && mAcc.size() > 0);
                if (complete) begin
                    if (free) modelEmit();
                    else      mPend = 1'b1;
                end
            end else if (free) begin
                modelEmit();
                mPend = 1'b0;
            end
        end
    endtask

    initial begin
        bus.RD_VALID  = 1'b0;
        bus.RD_DATA   = '0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b0;

        repeat (3) step(1, 0, 0, 0);
        @(posedge CLK);
        #1;
        check("reset_out", BW'({bus.OUT_WORDS, bus.OUT_DATA}), '0);
        check("reset_state", BW'(dbgState), BW'(FILL));

        // Streaming: 16 words, consumer always ready.
        seenQ.delete();
        srcQ = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 4; i < 16; i++) srcQ.push_back($urandom);
        repeat (18) step(0, 1, 0, 1);
        check("stream_beats", BW'(seenQ.size()), BW'(4));
        check("stream_first", seenQ[0], {CW'(4), 128'h44444444_33333333_22222222_11111111});

        // Backpressure: 9 words, consumer stalled, then a one-cycle ready pulse.
        seenQ.delete();
        for (int i = 0; i < 9; i++) srcQ.push_back($urandom);
        repeat (10) step(0, 1, 0, 0);
        check("bp_pend", BW'(dbgState), BW'(PEND));
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check("bp_refill", BW'(dbgState), BW'(FILL));
        // Partial flush while busy goes pending; the second flush lands in PEND and is ignored.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 1);
        check("bp_beats", BW'(seenQ.size()), BW'(3));
        check("pend_flush_words", BW'(seenQ[2][BW-1:DW]), BW'(1));

        // Partial flush of three words.
        seenQ.delete();
        srcQ.push_back(32'hA);
        srcQ.push_back(32'hB);
        srcQ.push_back(32'hC);
        repeat (3) step(0, 1, 0, 1);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 1);
        check("partial", seenQ[0], {CW'(3), 128'h00000000_0000000C_0000000B_0000000A});

        // Flush with an empty accumulator emits nothing.
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 1);
        check("flush_empty", BW'(seenQ.size()), BW'(1));

        // Flush together with the second accept.
        srcQ.push_back($urandom);
        srcQ.push_back($urandom);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        repeat (2) step(0, 0, 0, 1);
        check("flush_2nd", BW'(seenQ[seenQ.size()-1][BW-1:DW]), BW'(2));

        // Flush together with the fourth accept: exactly one full beat.
        for (int i = 0; i < 4; i++) srcQ.push_back($urandom);
        repeat (3) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 1);
        check("flush_4th_count", BW'(seenQ.size()), BW'(3));
        check("flush_4th_words", BW'(seenQ[seenQ.size()-1][BW-1:DW]), BW'(4));

        // Reset after two accepted words: they are dropped, next four pack from lane 0.
        for (int i = 0; i < 6; i++) begin
            w[i] = $urandom;
            srcQ.push_back(w[i]);
        end
        repeat (2) step(0, 1, 0, 1);
        step(1, 0, 0, 1);
        repeat (6) step(0, 1, 0, 1);
        check("reset_fill", seenQ[seenQ.size()-1], {CW'(4), w[5], w[4], w[3], w[2]});

        // Reset with a beat on the output and another pending.
        for (int i = 0; i < 8; i++) srcQ.push_back($urandom);
        repeat (9) step(0, 1, 0, 0);
        check("reset_pend_pre", BW'(dbgState), BW'(PEND));
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("reset_pend_post", BW'(dbgState), BW'(FILL));

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (srcQ.size() < 6 && $urandom_range(0, 3) != 0) srcQ.push_back($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 3);
        end
        repeat (6) step(0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
